// File: rtl/serial_ripple_subtractor_if.sv
// Start/busy/done handshake and operand/result bundle
// for the bit-serial subtractor.
interface serial_ripple_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial a - b - bin, LSB first, with one borrow
// flop carried between full-subtractor slices.
module serial_ripple_subtractor #(
  parameter int WIDTH = 4
) (
  input logic clk,
  input logic rst,
  serial_ripple_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             a_msb;
  logic             b_msb;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;

  logic             ai;
  logic             bi;
  logic             di;
  logic             br_nxt;
  logic [WIDTH-1:0] res_nxt;
  logic             last;

  assign ai      = a_sh[0];
  assign bi      = b_sh[0];
  assign di      = ai ^ bi ^ br;
  assign br_nxt  = (~ai & bi) | (~(ai ^ bi) & br);
  assign res_nxt = {di, res[WIDTH-1:1]};
  assign last    = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            br     <= bus.bin;
            a_msb  <= bus.a[WIDTH-1];
            b_msb  <= bus.b[WIDTH-1];
            res    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_nxt;
          res  <= res_nxt;
          // Counter stops on the last slice so it never wraps.
          if (last) begin
            state  <= DONE;
            done_q <= 1'b1;
            diff_q <= res_nxt;
            bout_q <= br_nxt;
            ovf_q  <= (a_msb != b_msb) &&
                      (res_nxt[WIDTH-1] != a_msb);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Self-checking bench: vector table, handshake corner
// cases, random ops and an exhaustive streaming sweep.
module tb_serial_ripple_subtractor;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_ripple_subtractor_if #(.WIDTH(W)) bus ();

  serial_ripple_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] diff;
    logic       bout;
    logic       ovf;
  } vec_t;

  int         checks   = 0;
  int         failures = 0;
  logic [3:0] last_diff;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, {ovf, bout, diff}.
  function automatic logic [5:0] model(input int a,
                                       input int b,
                                       input int c);
    int u;
    int s;
    logic o;
    logic bo;
    logic [3:0] d;
    u  = a - b - c;
    s  = (a >= 8 ? a - 16 : a) - (b >= 8 ? b - 16 : b) - c;
    o  = (s < -8) || (s > 7);
    bo = (u < 0);
    d  = 4'(u & 15);
    return {o, bo, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] av,
                        input logic [3:0] bv,
                        input logic       cv,
                        input logic [5:0] exp,
                        input string      nm);
    int n;
    int bc;
    bus.a     = av;
    bus.b     = bv;
    bus.bin   = cv;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a     = 4'($urandom);
    bus.b     = 4'($urandom);
    bus.bin   = 1'($urandom);
    chk({nm, " busy_rise"}, bus.busy, 1);
    chk({nm, " diff_hold"}, bus.diff, last_diff);
    n  = 0;
    bc = 1;
    while (bus.done !== 1'b1 && n < 20) begin
      tick();
      n++;
      bc += (bus.busy === 1'b1) ? 1 : 0;
    end
    chk({nm, " latency"}, n, W);
    chk({nm, " result"}, {bus.ovf, bus.bout, bus.diff}, exp);
    tick();
    chk({nm, " done_fall"}, bus.done, 0);
    chk({nm, " busy_fall"}, bus.busy, 0);
    chk({nm, " busy_cycles"}, bc, W + 1);
    last_diff = exp[3:0];
  endtask

  vec_t       tbl [5];
  logic [5:0] q [$];
  logic [5:0] e;

  initial begin
    int n;
    int pulses;
    int k;
    int cyc;
    int last_done;
    logic prev;

    tbl[0] = '{4'h7, 4'h3, 1'b0, 4'h4, 1'b0, 1'b0};
    tbl[1] = '{4'h3, 4'h5, 1'b0, 4'hE, 1'b1, 1'b0};
    tbl[2] = '{4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0};
    tbl[3] = '{4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1};
    tbl[4] = '{4'h7, 4'hF, 1'b0, 4'h8, 1'b1, 1'b1};

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    last_diff = '0;
    rst       = 1'b1;
    #12;
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset out", {bus.ovf, bus.bout, bus.diff}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    foreach (tbl[i])
      run_op(tbl[i].a, tbl[i].b, tbl[i].bin,
             {tbl[i].ovf, tbl[i].bout, tbl[i].diff},
             $sformatf("vec%0d", i));

    // start pulses during RUN and DONE must be ignored
    bus.a     = 4'h7;
    bus.b     = 4'h3;
    bus.bin   = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.a = 4'h1;
    bus.b = 4'h1;
    tick();
    bus.start = 1'b0;
    n = 1;
    while (bus.done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("ignore latency", n, W);
    chk("ignore result", bus.diff, 4'h4);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ignore busy_fall", bus.busy, 0);
    pulses = 0;
    repeat (8) begin
      tick();
      pulses += (bus.done === 1'b1) ? 1 : 0;
    end
    chk("ignore extra_done", pulses, 0);
    chk("ignore busy_idle", bus.busy, 0);
    chk("ignore diff_kept", bus.diff, 4'h4);
    last_diff = 4'h4;

    // asynchronous reset in the second RUN cycle
    bus.a     = 4'hC;
    bus.b     = 4'h1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    #3;
    rst = 1'b1;
    #1;
    chk("async busy", bus.busy, 0);
    chk("async done", bus.done, 0);
    chk("async out", {bus.ovf, bus.bout, bus.diff}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      tick();
      pulses += (bus.done === 1'b1) ? 1 : 0;
    end
    chk("async no_done", pulses, 0);
    last_diff = '0;
    run_op(4'h9, 4'h2, 1'b0, model(9, 2, 0), "post_rst");

    repeat (30) begin
      logic [3:0] ra;
      logic [3:0] rb;
      logic       rc;
      ra = 4'($urandom);
      rb = 4'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rc, model(int'(ra), int'(rb), int'(rc)), "rand");
    end

    // exhaustive sweep with start held high
    k         = 0;
    cyc       = 0;
    last_done = -1;
    prev      = bus.busy;
    bus.a     = 4'h0;
    bus.b     = 4'h0;
    bus.bin   = 1'b0;
    bus.start = 1'b1;
    while ((k < 512 || q.size() > 0) && cyc < 512 * 6 + 100) begin
      tick();
      cyc++;
      if (bus.busy === 1'b1 && prev === 1'b0 && k < 512) begin
        q.push_back(model(int'(bus.a), int'(bus.b), int'(bus.bin)));
        k++;
        if (k < 512) begin
          bus.a   = 4'(k >> 5);
          bus.b   = 4'((k >> 1) & 15);
          bus.bin = 1'(k & 1);
        end else begin
          bus.start = 1'b0;
        end
      end
      if (bus.done === 1'b1) begin
        if (q.size() == 0) begin
          chk("sweep spurious_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("sweep result", {bus.ovf, bus.bout, bus.diff}, e);
        end
        if (last_done >= 0)
          chk("sweep period", cyc - last_done, W + 2);
        last_done = cyc;
      end
      prev = bus.busy;
    end
    bus.start = 1'b0;
    chk("sweep issued", k, 512);
    chk("sweep drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_ripple_subtractor.md
# serial_ripple_subtractor

Bit-serial two's-complement subtractor for the LAB3 arithmetic set. It computes diff = a − b − bin one bit per clock, LSB first, holding a single borrow flip-flop between bit slices. It sits beside the combinational adders as their inverse operation, trading latency for one full-subtractor cell. A start/busy/done handshake lets a sequencer or testbench issue operations.

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; sampled with start
- b  input  WIDTH  subtrahend; sampled with start
- bin  input  1  borrow-in; sampled with start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; results valid
- diff  output  WIDTH  a − b − bin mod 2^WIDTH
- bout  output  1  final borrow; 1 iff a < b + bin (unsigned)
- ovf  output  1  signed overflow of the subtraction

## Operation
- States: IDLE, RUN, DONE; encoding is free.
- IDLE: if start=1 at an edge, latch a, b and bin into shift registers and the borrow flop. Clear the bit counter and go to RUN. Otherwise stay in IDLE.
- RUN: each edge processes bit i = counter, using the LSB of the shifted operand registers:
  - d_i = a_i ^ b_i ^ br
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - d_i shifts into the result register from the MSB side, so after WIDTH shifts bit 0 is at the LSB. Operand registers shift right.
  - counter increments.
- RUN exit: on the edge processing bit WIDTH−1, go to DONE. The same edge loads:
  - diff with the full result
  - bout with the final br_next
  - ovf = (a[W−1] ≠ b[W−1]) & (diff[W−1] ≠ a[W−1]), using latched a and b and the new diff.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- start is ignored in RUN and DONE; there is no queueing.
- diff, bout and ovf change only on a DONE-entry edge or on reset. They hold their last result otherwise, including through the next RUN.
- Inputs a, b and bin may change freely after the start edge.
- Counter width is ceil(log2(WIDTH)) bits. It never wraps within an operation.

## Timing
- Reset (asynchronous, takes effect immediately, any state):
  - state = IDLE; busy = 0, done = 0, diff = 0, bout = 0, ovf = 0
  - internal shift registers, counter and borrow flop cleared
  - an operation in flight is abandoned with no done pulse
- Release of rst: the first rising edge with rst=0 may accept start.
- Latency, with start sampled at edge E0:
  - busy rises after E0.
  - Bits 0..WIDTH−1 are processed at E1..E_WIDTH.
  - Results and done are valid after E_WIDTH; done falls after E_WIDTH+1; busy falls after E_WIDTH+1.
  - Earliest next start is sampled at E_WIDTH+2.
  - Throughput: one operation per WIDTH+2 cycles.
- A start held continuously high starts a new operation at every IDLE edge. That gives back-to-back operations separated by one IDLE cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset then a=7, b=3, bin=0, one-cycle start → done after 4 edges (WIDTH=4): diff=4, bout=0, ovf=0; busy high for 5 cycles.
- a=3, b=5, bin=0 → diff=0xE, bout=1, ovf=0. Then a=0, b=0, bin=1 → diff=0xF, bout=1, ovf=0.
- a=0x8, b=0x1 → diff=0x7, bout=0, ovf=1. Also a=0x7, b=0xF → diff=0x8, bout=1, ovf=1.
- Start 7−3, then pulse start with a=1, b=1 during RUN and again in the DONE cycle → only one done pulse; result 4.
- Assert rst asynchronously (mid-cycle) at the second RUN cycle → all outputs 0 immediately, no done. Then 9−2 → diff=7, bout=0.
- Exhaustive sweep of a, b over 0..15 and bin over 0..1, with start held high → each result matches a−b−bin mod 16 and the borrow/overflow formulas; done period is 6 cycles.
